// File: rtl/slot_allocator_if.sv
// Allocation/return handshake bundle between a slot consumer and slot_allocator.
// The consumer side drives requests (master); the allocator answers with
// one-cycle grant/nack pulses and the granted index (slave).
interface slot_allocator_if;
  logic       alloc_req;
  logic       alloc_gnt;
  logic       alloc_nack;
  logic [3:0] alloc_idx;
  logic       free_req;
  logic [3:0] free_idx;

  modport master (
    output alloc_req,
    output free_req,
    output free_idx,
    input  alloc_gnt,
    input  alloc_nack,
    input  alloc_idx
  );

  modport slave (
    input  alloc_req,
    input  free_req,
    input  free_idx,
    output alloc_gnt,
    output alloc_nack,
    output alloc_idx
  );
endinterface

// File: rtl/slot_allocator.sv
// slot_allocator: registered 16-slot allocator.
// Keeps a busy bitmap, feeds it to an external lowest-zero priority encoder
// (busy -> enc_out, combinational) and uses the encoder result to grant the
// lowest free slot one cycle after a request. Slots are returned with
// free_req/free_idx. used_cnt, full and empty are registered with the bitmap.
// Optional feature macro: SLOT_ALLOC_ERR_EN adds a sticky err output that
// flags frees of idle slots and out-of-range encoder results (> 16).
module slot_allocator (
  input  logic              clk,
  input  logic              rst,
  slot_allocator_if.slave   bus,
  output logic [15:0]       busy,
  input  logic [4:0]        enc_out,
  output logic [4:0]        used_cnt,
  output logic              full,
  output logic              empty
`ifdef SLOT_ALLOC_ERR_EN
  ,
  output logic              err
`endif
);

  // Slot count and index width are tied to the 16-bit encoder.
  localparam int N_SLOTS = 16;
  localparam int IDX_W   = 4;

  // Architectural state
  logic [N_SLOTS-1:0] busy_reg;
  logic [N_SLOTS-1:0] busy_next;
  logic [4:0]         used_cnt_reg;
  logic [4:0]         used_cnt_next;
  logic               full_reg;
  logic               empty_reg;

  // Response registers
  logic               alloc_gnt_reg;
  logic               alloc_nack_reg;
  logic [IDX_W-1:0]   alloc_idx_reg;

  // Decoded request qualifiers, all based on the pre-edge bitmap
  logic               none_free;
  logic               alloc_ok;
  logic               alloc_refused;
  logic               free_ok;
  logic [IDX_W-1:0]   alloc_slot;

  // enc_out[4] covers both "16 = none free" and any out-of-range code above 16,
  // so a corrupt encoder result can never produce a grant.
  assign none_free     = enc_out[4];
  assign alloc_slot    = enc_out[IDX_W-1:0];
  assign alloc_ok      = bus.alloc_req && !none_free;
  assign alloc_refused = bus.alloc_req && none_free;
  assign free_ok       = bus.free_req && busy_reg[bus.free_idx];

  // Per-slot next-state: the allocated slot is clear pre-edge and the freed
  // slot is set pre-edge, so set and clear never target the same bit.
  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      logic set_bit;
      logic clr_bit;
      assign set_bit       = alloc_ok && (alloc_slot == IDX_W'(gi));
      assign clr_bit       = free_ok && (bus.free_idx == IDX_W'(gi));
      assign busy_next[gi] = (busy_reg[gi] && !clr_bit) || set_bit;
    end
  endgenerate

  // Count tracks popcount(busy): +1 per grant, -1 per effective free.
  always_comb begin
    used_cnt_next = used_cnt_reg;
    if (alloc_ok && !free_ok) begin
      used_cnt_next = used_cnt_reg + 5'd1;
    end else if (!alloc_ok && free_ok) begin
      used_cnt_next = used_cnt_reg - 5'd1;
    end
  end

  // Bitmap, counter and occupancy flags advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg     <= '0;
      used_cnt_reg <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
    end else begin
      busy_reg     <= busy_next;
      used_cnt_reg <= used_cnt_next;
      full_reg     <= (used_cnt_next == 5'(N_SLOTS));
      empty_reg    <= (used_cnt_next == 5'd0);
    end
  end

  // Grant/nack are single-cycle pulses; the index holds until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_gnt_reg  <= 1'b0;
      alloc_nack_reg <= 1'b0;
      alloc_idx_reg  <= '0;
    end else begin
      alloc_gnt_reg  <= alloc_ok;
      alloc_nack_reg <= alloc_refused;
      if (alloc_ok) begin
        alloc_idx_reg <= alloc_slot;
      end
    end
  end

`ifdef SLOT_ALLOC_ERR_EN
  logic err_reg;
  logic err_event;

  assign err_event = (bus.free_req && !busy_reg[bus.free_idx]) ||
                     (enc_out > 5'd16);

  // Sticky error: once set, only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (err_event) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

  assign busy           = busy_reg;
  assign used_cnt       = used_cnt_reg;
  assign full           = full_reg;
  assign empty          = empty_reg;
  assign bus.alloc_gnt  = alloc_gnt_reg;
  assign bus.alloc_nack = alloc_nack_reg;
  assign bus.alloc_idx  = alloc_idx_reg;

endmodule

// File: tb/tb_slot_allocator.sv
// Testbench for slot_allocator. A behavioural lowest-zero encoder closes the
// busy -> enc_out loop. Stimulus pushes the expected grant/nack response into
// a queue; an independent monitor pops and compares whenever a pulse appears.
// Bitmap/counter/flag state is compared directly after each edge.
module tb_slot_allocator;

  typedef struct {
    bit         gnt;
    bit         nack;
    logic [3:0] idx;
  } resp_t;

  logic        clk;
  logic        rst;
  logic [15:0] busy;
  logic [4:0]  enc_out;
  logic [4:0]  used_cnt;
  logic        full;
  logic        empty;
`ifdef SLOT_ALLOC_ERR_EN
  logic        err;
`endif

  int    checks;
  int    failures;
  resp_t exp_q[$];

  slot_allocator_if bus ();

  slot_allocator dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .enc_out  (enc_out),
    .used_cnt (used_cnt),
    .full     (full),
    .empty    (empty)
`ifdef SLOT_ALLOC_ERR_EN
    ,
    .err      (err)
`endif
  );

  // Reference encoder: lowest clear bit index, 16 when all set.
  always_comb begin
    enc_out = 5'd16;
    for (int i = 15; i >= 0; i--) begin
      if (!busy[i]) enc_out = 5'(i);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // kind: 0 = no response expected, 1 = grant of exp_idx, 2 = nack
  task automatic cycle(input bit areq, input bit freq, input logic [3:0] fidx,
                       input int kind, input logic [3:0] exp_idx);
    resp_t r;
    if (kind != 0) begin
      r.gnt  = (kind == 1);
      r.nack = (kind == 2);
      r.idx  = exp_idx;
      exp_q.push_back(r);
    end
    bus.alloc_req = areq;
    bus.free_req  = freq;
    bus.free_idx  = fidx;
    @(posedge clk);
    #1;
    $display("txn alloc=%0b free=%0b fidx=%0d -> busy=%04h used=%0d full=%0b empty=%0b",
             areq, freq, fidx, busy, used_cnt, full, empty);
    bus.alloc_req = 1'b0;
    bus.free_req  = 1'b0;
    bus.free_idx  = 4'd0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [15:0] b, input logic [4:0] u,
                             input bit f, input bit e);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_used"}, 32'(used_cnt), 32'(u));
    check({tag, "_full"}, 32'(full), 32'(f));
    check({tag, "_empty"}, 32'(empty), 32'(e));
  endtask

  // Monitor: every grant/nack pulse must match the oldest expected response.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.alloc_gnt === 1'b1 || bus.alloc_nack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse gnt=%0b nack=%0b idx=%0d expected=none",
                   bus.alloc_gnt, bus.alloc_nack, bus.alloc_idx);
        end else begin
          e = exp_q.pop_front();
          if (bus.alloc_gnt !== e.gnt || bus.alloc_nack !== e.nack ||
              (e.gnt && bus.alloc_idx !== e.idx)) begin
            failures++;
            $display("FAIL alloc_resp gnt=%0b nack=%0b idx=%0d expected gnt=%0b nack=%0b idx=%0d",
                     bus.alloc_gnt, bus.alloc_nack, bus.alloc_idx, e.gnt, e.nack, e.idx);
          end else begin
            $display("resp gnt=%0b nack=%0b idx=%0d", bus.alloc_gnt, bus.alloc_nack, bus.alloc_idx);
          end
        end
      end
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.alloc_req = 1'b0;
    bus.free_req  = 1'b0;
    bus.free_idx  = 4'd0;
    @(posedge clk);
    reset_dut();

    // Reset state
    check_state("reset", 16'h0000, 5'd0, 1'b0, 1'b1);
    check("reset_gnt", 32'(bus.alloc_gnt), 32'd0);
    check("reset_nack", 32'(bus.alloc_nack), 32'd0);
    check("reset_idx", 32'(bus.alloc_idx), 32'd0);
`ifdef SLOT_ALLOC_ERR_EN
    check("reset_err", 32'(err), 32'd0);
`endif

    // 16 back-to-back grants 0..15, then a nack
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'd0, 1, 4'(i));
    check_state("fill16", 16'hFFFF, 5'd16, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 2, 4'd0);
    check_state("full_nack", 16'hFFFF, 5'd16, 1'b1, 1'b0);
    check("idx_hold_after_nack", 32'(bus.alloc_idx), 32'd15);

    // Free slot 5 from full, then re-allocate it
    cycle(1'b0, 1'b1, 4'd5, 0, 4'd0);
    check_state("free5", 16'hFFDF, 5'd15, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1, 4'd5);
    check_state("realloc5", 16'hFFFF, 5'd16, 1'b1, 1'b0);

    // Alloc while full with a simultaneous free of 9: nack, free completes
    cycle(1'b1, 1'b1, 4'd9, 2, 4'd0);
    check_state("full_alloc_free9", 16'hFDFF, 5'd15, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1, 4'd9);
    check_state("realloc9", 16'hFFFF, 5'd16, 1'b1, 1'b0);

    // From 000F: alloc + free 2 together grants 4, count unchanged
    reset_dut();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'd0, 1, 4'(i));
    check_state("busy_000f", 16'h000F, 5'd4, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'd2, 1, 4'd4);
    check_state("alloc_free2", 16'h001B, 5'd4, 1'b0, 1'b0);
    // Slot 2 is idle now: freeing it again changes nothing
    cycle(1'b0, 1'b1, 4'd2, 0, 4'd0);
    check_state("free_idle2", 16'h001B, 5'd4, 1'b0, 1'b0);
    // Freed slot 2 is the next grant
    cycle(1'b1, 1'b0, 4'd0, 1, 4'd2);
    check_state("realloc2", 16'h001F, 5'd5, 1'b0, 1'b0);

    // Free of idle slot 7 from empty
    reset_dut();
    cycle(1'b0, 1'b1, 4'd7, 0, 4'd0);
    check_state("free_idle7", 16'h0000, 5'd0, 1'b0, 1'b1);
`ifdef SLOT_ALLOC_ERR_EN
    check("err_set", 32'(err), 32'd1);
    cycle(1'b0, 1'b0, 4'd0, 0, 4'd0);
    check("err_sticky", 32'(err), 32'd1);
`endif

    // Reset with a same-cycle alloc request while busy=00FF
    reset_dut();
`ifdef SLOT_ALLOC_ERR_EN
    check("err_cleared", 32'(err), 32'd0);
`endif
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'd0, 1, 4'(i));
    check_state("busy_00ff", 16'h00FF, 5'd8, 1'b0, 1'b0);
    rst           = 1'b1;
    bus.alloc_req = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.alloc_req = 1'b0;
    check_state("rst_alloc", 16'h0000, 5'd0, 1'b0, 1'b1);
    check("rst_alloc_gnt", 32'(bus.alloc_gnt), 32'd0);
    check("rst_alloc_idx", 32'(bus.alloc_idx), 32'd0);
    cycle(1'b0, 1'b0, 4'd0, 0, 4'd0);
    check("post_rst_gnt", 32'(bus.alloc_gnt), 32'd0);
    cycle(1'b1, 1'b0, 4'd0, 1, 4'd0);
    check_state("post_rst_alloc", 16'h0001, 5'd1, 1'b0, 1'b0);

    // Drain: every expected response must have been seen
    repeat (3) @(posedge clk);
    #1;
    check("pending_responses", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slot_allocator.md
# slot_allocator

Registered 16-slot allocator that tracks a busy bitmap and hands out free slot indices on request. It sits directly upstream of `ZeroPriorityEnc`: it drives the encoder's 16-bit input with the current busy bitmap and consumes the encoder's 5-bit result, the lowest clear bit index or 16 when none is clear. Consumers use it to allocate and return slots in SPU buffer and tag pools.

## Interface
- `N_SLOTS`, 16: number of slots. Fixed by the encoder width; any other value is unsupported.
- `IDX_W`, 4: slot index width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `alloc_req` input 1: request one slot this cycle.
- `alloc_gnt` output 1: one-cycle pulse; `alloc_idx` is valid.
- `alloc_nack` output 1: one-cycle pulse; the request was refused because no slot was free.
- `alloc_idx` output 4: granted slot index.
- `free_req` input 1: return slot `free_idx` this cycle.
- `free_idx` input 4: slot being returned.
- `busy` output 16: current busy bitmap, bit i = slot i in use. Drives the encoder `in`.
- `enc_out` input 5: encoder result; 0–15 = lowest free slot, 16 = none free.
- `used_cnt` output 5: number of busy slots, 0–16.
- `full` output 1: `used_cnt == 16`.
- `empty` output 1: `used_cnt == 0`.
- `err` output 1: sticky error flag. Present only with `SLOT_ALLOC_ERR_EN`.

## Operation
- **State:** `busy[15:0]` register, `used_cnt` register, and output registers for grant, nack and index.
- **Allocate:** on an edge with `alloc_req=1`:
  - If `enc_out[4]==0`: set `busy[enc_out[3:0]]`, drive `alloc_gnt=1` and `alloc_idx=enc_out[3:0]` in the next cycle, and increment `used_cnt`.
  - If `enc_out[4]==1`: drive `alloc_nack=1` in the next cycle; `busy` is unchanged.
- **Free:** on an edge with `free_req=1` and `busy[free_idx]==1`: clear the bit and decrement `used_cnt`.
- **Simultaneous alloc and free:**
  - Allocation uses the pre-edge bitmap, so a slot freed this cycle is never granted this cycle.
  - When both succeed, `used_cnt` is unchanged.
  - Alloc while full together with a free: the alloc is nacked, the free completes, and the next cycle's alloc succeeds.
- **Free of an idle slot** (`busy[free_idx]==0`): no change to `busy` or `used_cnt`.
- **Ordering:** allocation is always the lowest free index. No fairness or rotation.
- **Counter rule:** `used_cnt` never wraps. It equals the popcount of `busy` at all times.

## Timing
- **Reset values:** `busy=16'h0000`, `used_cnt=0`, `alloc_gnt=0`, `alloc_nack=0`, `alloc_idx=0`, `empty=1`, `full=0`, `err=0`.
- **Reset priority:** `rst` overrides any same-cycle request. No in-flight grant survives reset; the pulse in the cycle after reset is 0.
- **Encoder path:** `busy` → encoder → `enc_out` is combinational within one cycle.
- **Alloc latency:** 1 cycle from the `alloc_req` edge to the `alloc_gnt`/`alloc_nack` pulse. Back-to-back requests are accepted every cycle: 16 consecutive requests from empty grant 0,1,…,15 on consecutive cycles; the 17th is nacked.
- **Grant/nack pulses:** each lasts exactly 1 cycle; `alloc_idx` holds its value until the next grant.
- **Free latency:** the freed slot is visible in `busy` and `enc_out` 1 cycle after the `free_req` edge.
- **Flags:** `full` and `empty` are registered alongside `used_cnt`.

## Configuration
- `SLOT_ALLOC_ERR_EN` defined:
  - `err` port exists.
  - `err` is set on any free of an idle slot, or on `enc_out` > 16.
  - `err` is cleared only by `rst`.
- `SLOT_ALLOC_ERR_EN` undefined:
  - `err` port and its logic are omitted.
  - Illegal frees are silently ignored; `enc_out` > 16 is treated as none-free.

## Test plan
- Reset, then 17 consecutive `alloc_req` cycles → `alloc_gnt` with `alloc_idx` 0..15 on cycles 1–16; cycle 17 gives `alloc_nack=1`; `full=1`, `used_cnt=16`, `busy=16'hFFFF`.
- From full, free slot 5, then alloc → grant `alloc_idx=5`; `busy` returns to `16'hFFFF`.
- From full, `alloc_req` and `free_req` (idx 9) in the same cycle → `alloc_nack=1`, `busy=16'hFDFF`, `used_cnt=15`; alloc next cycle → `alloc_idx=9`.
- With `busy=16'h000F`, alloc and free idx 2 in the same cycle → `alloc_idx=4`, `busy=16'h001B`, `used_cnt` stays 4.
- Free idx 7 while `busy=16'h0000` → `busy` stays 0 and `used_cnt` stays 0; `err=1` with `SLOT_ALLOC_ERR_EN`, port absent without it.
- Assert `rst` in the same cycle as `alloc_req` with `busy=16'h00FF` → next cycle `busy=0`, `alloc_gnt=0`, `empty=1`.
